sne_apb_cfg_loader: RTL and testbench

SNE_APB_CFG_LOADER -- requirements
Module: sne_apb_cfg_loader

---
 rtl/sne_apb_cfg_loader_if.sv | 35 +++
 rtl/sne_apb_cfg_loader.sv | 184 ++++++++++++++++++
 tb/tb_sne_apb_cfg_loader.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sne_apb_cfg_loader_if.sv
// TCDM read-master and APB-master signal bundle of the SNE configuration loader.
// Signal names are from the loader's point of view (_o driven by the loader).
interface sne_apb_cfg_loader_if;
    logic        tcdm_req_o;
    logic        tcdm_gnt_i;
    logic [31:0] tcdm_add_o;
    logic        tcdm_wen_o;
    logic [3:0]  tcdm_be_o;
    logic [31:0] tcdm_data_o;
    logic [31:0] tcdm_r_data_i;
    logic        tcdm_r_valid_i;

    logic [31:0] apb_paddr_o;
    logic [31:0] apb_pwdata_o;
    logic        apb_pwrite_o;
    logic        apb_psel_o;
    logic        apb_penable_o;
    logic [31:0] apb_prdata_i;
    logic        apb_pready_i;
    logic        apb_pslverr_i;

    modport master (
        output tcdm_req_o, tcdm_add_o, tcdm_wen_o, tcdm_be_o, tcdm_data_o,
        input  tcdm_gnt_i, tcdm_r_data_i, tcdm_r_valid_i,
        output apb_paddr_o, apb_pwdata_o, apb_pwrite_o, apb_psel_o, apb_penable_o,
        input  apb_prdata_i, apb_pready_i, apb_pslverr_i
    );

    modport slave (
        input  tcdm_req_o, tcdm_add_o, tcdm_wen_o, tcdm_be_o, tcdm_data_o,
        output tcdm_gnt_i, tcdm_r_data_i, tcdm_r_valid_i,
        input  apb_paddr_o, apb_pwdata_o, apb_pwrite_o, apb_psel_o, apb_penable_o,
        output apb_prdata_i, apb_pready_i, apb_pslverr_i
    );
endinterface

// File: rtl/sne_apb_cfg_loader.sv
// Replays a TCDM-resident list of 8-byte {addr/opcode, data} entries as APB writes
// and timed waits towards the SNE configuration slave.
module sne_apb_cfg_loader #(
    parameter int unsigned MAX_WAIT_W = 16
) (
    input  logic                 system_clk_i,
    input  logic                 system_rst_ni,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [31:0]          base_addr_i,
    input  logic [15:0]          num_entries_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o,
    sne_apb_cfg_loader_if.master bus
);

    typedef enum logic [2:0] {
        IDLE, RD_A, RD_D, DECODE, APB_SETUP, APB_ACCESS, DELAY, FINISH
    } state_e;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_WAIT  = 2'b01;
    localparam logic [1:0] OP_END   = 2'b11;

    state_e                state_q, state_d;
    logic [31:0]           base_q, base_d;
    logic [15:0]           num_q, num_d;
    logic [15:0]           k_q, k_d;
    logic [31:0]           word0_q, word0_d;
    logic [31:0]           data_q, data_d;
    logic [MAX_WAIT_W-1:0] cnt_q, cnt_d;
    logic                  abort_q, abort_d;
    logic                  error_q, error_d;
    logic                  gnt_q, gnt_d;

    logic [31:0] entry_addr;
    logic [15:0] k_next;
    logic        abort_now;

    assign entry_addr = base_q + {13'b0, k_q, 3'b000};
    assign k_next     = k_q + 16'd1;
    assign abort_now  = abort_i | abort_q;

    // NOTE: every output and next-state value gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        num_d   = num_q;
        k_d     = k_q;
        word0_d = word0_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        abort_d = abort_q;
        error_d = error_q;
        gnt_d   = gnt_q;

        bus.tcdm_req_o    = 1'b0;
        bus.tcdm_add_o    = 32'h0;
        bus.tcdm_wen_o    = 1'b1;
        bus.tcdm_be_o     = 4'hF;
        bus.tcdm_data_o   = 32'h0;
        bus.apb_psel_o    = 1'b0;
        bus.apb_penable_o = 1'b0;
        bus.apb_pwrite_o  = 1'b0;
        bus.apb_paddr_o   = 32'h0;
        bus.apb_pwdata_o  = 32'h0;

        busy_o  = (state_q != IDLE) && (state_q != FINISH);
        done_o  = (state_q == FINISH);
        error_o = error_q;

        // An abort seen mid-handshake is held until the next safe point.
        if (abort_i && busy_o) abort_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                if (start_i) begin
                    base_d  = base_addr_i;
                    num_d   = num_entries_i;
                    k_d     = 16'd0;
                    error_d = 1'b0;
                    gnt_d   = 1'b0;
                    state_d = (num_entries_i == 16'd0) ? FINISH : RD_A;
                end
            end
            RD_A, RD_D: begin
                if (!gnt_q) begin
                    bus.tcdm_req_o = 1'b1;
                    bus.tcdm_add_o = (state_q == RD_A) ? entry_addr : entry_addr + 32'd4;
                    if (bus.tcdm_gnt_i) gnt_d = 1'b1;
                end else if (bus.tcdm_r_valid_i) begin
                    gnt_d = 1'b0;
                    if (state_q == RD_A) word0_d = bus.tcdm_r_data_i;
                    else                 data_d  = bus.tcdm_r_data_i;
                    if (abort_now)             state_d = FINISH;
                    else if (state_q == RD_A)  state_d = RD_D;
                    else                       state_d = DECODE;
                end
            end
            DECODE: begin
                if (abort_now) begin
                    state_d = FINISH;
                end else begin
                    unique case (word0_q[1:0])
                        OP_WRITE: state_d = APB_SETUP;
                        OP_WAIT: begin
                            cnt_d   = data_q[MAX_WAIT_W-1:0];
                            state_d = DELAY;
                        end
                        OP_END:  state_d = FINISH;
                        default: begin
                            error_d = 1'b1;
                            state_d = FINISH;
                        end
                    endcase
                end
            end
            APB_SETUP, APB_ACCESS: begin
                bus.apb_psel_o    = 1'b1;
                bus.apb_penable_o = (state_q == APB_ACCESS);
                bus.apb_pwrite_o  = 1'b1;
                bus.apb_paddr_o   = {word0_q[31:2], 2'b00};
                bus.apb_pwdata_o  = data_q;
                if (state_q == APB_SETUP) begin
                    state_d = APB_ACCESS;
                end else if (bus.apb_pready_i) begin
                    if (bus.apb_pslverr_i) begin
                        error_d = 1'b1;
                        state_d = FINISH;
                    end else begin
                        k_d     = k_next;
                        state_d = (k_next == num_q || abort_now) ? FINISH : RD_A;
                    end
                end
            end
            DELAY: begin
                // A zero count still spends one cycle here.
                if (abort_now) begin
                    state_d = FINISH;
                end else if (cnt_q == '0 || cnt_q == MAX_WAIT_W'(1)) begin
                    k_d     = k_next;
                    state_d = (k_next == num_q) ? FINISH : RD_A;
                end else begin
                    cnt_d = cnt_q - MAX_WAIT_W'(1);
                end
            end
            FINISH: begin
                abort_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
    always_ff @(posedge system_clk_i or negedge system_rst_ni) begin
        if (!system_rst_ni) begin
            state_q <= IDLE;
            base_q  <= 32'h0;
            num_q   <= 16'h0;
            k_q     <= 16'h0;
            word0_q <= 32'h0;
            data_q  <= 32'h0;
            cnt_q   <= '0;
            abort_q <= 1'b0;
            error_q <= 1'b0;
            gnt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            num_q   <= num_d;
            k_q     <= k_d;
            word0_q <= word0_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
            error_q <= error_d;
            gnt_q   <= gnt_d;
        end
    end

endmodule

// File: tb/tb_sne_apb_cfg_loader.sv
// Self-checking bench for sne_apb_cfg_loader: TCDM and APB slave models plus a
// list-level reference model of the expected read, write, wait and error behaviour.
module tb_sne_apb_cfg_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [31:0] base_addr = 32'h0;
    logic [15:0] num_entries = 16'h0;
    logic        busy_o, done_o, error_o;

    sne_apb_cfg_loader_if bus ();

    sne_apb_cfg_loader #(.MAX_WAIT_W(16)) dut (
        .system_clk_i  (clk),
        .system_rst_ni (rst_n),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .base_addr_i   (base_addr),
        .num_entries_i (num_entries),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .error_o       (error_o),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory image, slave knobs and observation logs.
    bit [31:0] mem [bit [31:0]];
    int        stall_pct = 0, rv_extra = 0, ws_min = 0, ws_max = 0, err_at_write = -1;
    bit [31:0] cur_base = 0;
    bit [31:0] rd_q[$], wr_addr_q[$], wr_data_q[$];
    int        gap_by_entry [int];
    int        viol = 0, wr_count = 0;

    // Reference results.
    bit [31:0] exp_reads[$], exp_waddr[$], exp_wdata[$];
    int        exp_gap [int];
    bit        exp_err;

    // TCDM slave: random grant stalls, rvalid 1..1+rv_extra cycles after grant.
    initial begin
        bit        pend = 0, prev_stall = 0, prev_req = 0, last_word1 = 0;
        bit [31:0] pend_addr = 0, prev_add = 0;
        int        rv_wait = 0, ncyc = 0, last_rv = 0, last_entry = 0;
        bus.tcdm_gnt_i = 0; bus.tcdm_r_valid_i = 0; bus.tcdm_r_data_i = 0;
        forever begin
            @(negedge clk);
            ncyc++;
            bus.tcdm_gnt_i = 0; bus.tcdm_r_valid_i = 0;
            if (!rst_n) begin
                pend = 0; prev_stall = 0; prev_req = 0; last_word1 = 0;
            end else begin
                if (pend) begin
                    if (rv_wait == 0) begin
                        bus.tcdm_r_valid_i = 1; bus.tcdm_r_data_i = mem[pend_addr]; pend = 0;
                        last_rv = ncyc; last_entry = int'((pend_addr - cur_base) >> 3);
                        last_word1 = pend_addr[2];
                    end else rv_wait--;
                end
                if (bus.tcdm_req_o) begin
                    if (pend) viol++;
                    if (prev_stall && bus.tcdm_add_o !== prev_add) viol++;
                    if (!prev_req && last_word1) begin
                        gap_by_entry[last_entry] = ncyc - last_rv; last_word1 = 0;
                    end
                    if (!pend && $urandom_range(99) >= stall_pct) begin
                        bus.tcdm_gnt_i = 1; rd_q.push_back(bus.tcdm_add_o);
                        pend = 1; pend_addr = bus.tcdm_add_o; rv_wait = $urandom_range(rv_extra, 0);
                    end
                    prev_stall = !bus.tcdm_gnt_i; prev_add = bus.tcdm_add_o;
                end else begin
                    if (prev_stall) viol++;
                    prev_stall = 0;
                end
                if (bus.tcdm_req_o && bus.apb_psel_o) viol++;
                if (bus.tcdm_req_o && (bus.tcdm_wen_o !== 1'b1 || bus.tcdm_be_o !== 4'hF)) viol++;
                prev_req = bus.tcdm_req_o;
            end
        end
    end

    // APB slave: ws_min..ws_max wait states, pslverr on write number err_at_write.
    initial begin
        bit [31:0] s_addr = 0, s_data = 0;
        int        ws = 0;
        bus.apb_pready_i = 0; bus.apb_pslverr_i = 0; bus.apb_prdata_i = 0;
        forever begin
            @(negedge clk);
            bus.apb_pready_i = 0; bus.apb_pslverr_i = 0;
            if (bus.apb_psel_o && !bus.apb_penable_o) begin
                s_addr = bus.apb_paddr_o; s_data = bus.apb_pwdata_o;
                ws = $urandom_range(ws_max, ws_min);
                if (bus.apb_pwrite_o !== 1'b1) viol++;
            end else if (bus.apb_psel_o && bus.apb_penable_o) begin
                if (bus.apb_paddr_o !== s_addr || bus.apb_pwdata_o !== s_data || bus.apb_pwrite_o !== 1'b1) viol++;
                if (ws == 0) begin
                    bus.apb_pready_i = 1;
                    bus.apb_pslverr_i = (wr_count == err_at_write);
                    wr_addr_q.push_back(bus.apb_paddr_o); wr_data_q.push_back(bus.apb_pwdata_o);
                    wr_count++;
                end else ws--;
            end
        end
    end

    // List-level model: which words get read, which writes go out, which waits
    // happen (gap = DECODE cycle + max(N,1) DELAY cycles + 1) and whether error ends the run.
    task automatic model(input bit [31:0] b, input int n, input int err_w, input int abort_w);
        bit [31:0] a, w0, w1;
        int        wi = 0;
        exp_reads.delete(); exp_waddr.delete(); exp_wdata.delete(); exp_gap.delete(); exp_err = 0;
        for (int k = 0; k < n; k++) begin
            a = b + 32'(k * 8);
            w0 = mem[a]; w1 = mem[a + 32'd4];
            exp_reads.push_back(a); exp_reads.push_back(a + 32'd4);
            case (w0[1:0])
                2'b00: begin
                    exp_waddr.push_back(w0 & 32'hFFFF_FFFC); exp_wdata.push_back(w1);
                    if (wi == err_w) begin exp_err = 1; return; end
                    if (wi == abort_w) return;
                    wi++;
                end
                2'b01: if (k + 1 < n) exp_gap[k] = ((w1[15:0] == 0) ? 1 : int'(w1[15:0])) + 2;
                2'b11: return;
                default: begin exp_err = 1; return; end
            endcase
        end
    endtask

    task automatic run(input string tag, input bit [31:0] b, input int n,
                       input int err_w, input int abort_w, input int exp_lat);
        int lat = 0;
        bit seen = 0, arm = (abort_w >= 0);
        rd_q.delete(); wr_addr_q.delete(); wr_data_q.delete(); gap_by_entry.delete();
        wr_count = 0; viol = 0; err_at_write = err_w; cur_base = b;
        model(b, n, err_w, abort_w);
        @(negedge clk);
        base_addr = b; num_entries = n[15:0]; start_i = 1;
        @(negedge clk);
        start_i = 0;
        check({tag, ".err_clr_on_start"}, error_o, 1'b0);
        for (int c = 0; c < 3000 && !seen; c++) begin
            lat++;
            if (done_o) seen = 1;
            else begin
                abort_i = 0;
                if (arm && bus.apb_psel_o && bus.apb_penable_o) begin abort_i = 1; arm = 0; end
                @(negedge clk);
            end
        end
        abort_i = 0;
        check({tag, ".done_seen"}, seen, 1'b1);
        if (exp_lat > 0) check({tag, ".done_latency"}, lat, exp_lat);
        check({tag, ".busy_at_done"}, busy_o, 1'b0);
        @(negedge clk);
        check({tag, ".done_one_cycle"}, done_o, 1'b0);
        check({tag, ".error"}, error_o, exp_err);
        check({tag, ".protocol_violations"}, viol, 0);
        check({tag, ".n_reads"}, rd_q.size(), exp_reads.size());
        for (int i = 0; i < rd_q.size() && i < exp_reads.size(); i++)
            check($sformatf("%s.read%0d", tag, i), rd_q[i], exp_reads[i]);
        check({tag, ".n_writes"}, wr_addr_q.size(), exp_waddr.size());
        for (int i = 0; i < wr_addr_q.size() && i < exp_waddr.size(); i++) begin
            check($sformatf("%s.paddr%0d", tag, i), wr_addr_q[i], exp_waddr[i]);
            check($sformatf("%s.pwdata%0d", tag, i), wr_data_q[i], exp_wdata[i]);
        end
        foreach (exp_gap[k])
            check($sformatf("%s.wait_gap_e%0d", tag, k),
                  gap_by_entry.exists(k) ? gap_by_entry[k] : -1, exp_gap[k]);
    endtask

    task automatic load_entry(input bit [31:0] b, input int k, input bit [31:0] w0, input bit [31:0] w1);
        mem[b + 32'(k * 8)] = w0; mem[b + 32'(k * 8) + 32'd4] = w1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".busy"}, busy_o, 1'b0);       check({tag, ".done"}, done_o, 1'b0);
        check({tag, ".error"}, error_o, 1'b0);     check({tag, ".req"}, bus.tcdm_req_o, 1'b0);
        check({tag, ".add"}, bus.tcdm_add_o, 0);   check({tag, ".wen"}, bus.tcdm_wen_o, 1'b1);
        check({tag, ".be"}, bus.tcdm_be_o, 4'hF);  check({tag, ".wdata"}, bus.tcdm_data_o, 0);
        check({tag, ".psel"}, bus.apb_psel_o, 1'b0);
        check({tag, ".penable"}, bus.apb_penable_o, 1'b0);
        check({tag, ".pwrite"}, bus.apb_pwrite_o, 1'b0);
        check({tag, ".paddr"}, bus.apb_paddr_o, 0);
        check({tag, ".pwdata"}, bus.apb_pwdata_o, 0);
    endtask

    initial begin
        bit [31:0] b, w0, w1;
        int        n, sel, nrd;
        bit        found;

        #1 check_reset_outputs("reset");
        @(negedge clk); @(negedge clk);
        rst_n = 1;

        // Directed reference list.
        load_entry(32'h100, 0, 32'h1A10_0000, 32'hDEAD_BEEF);
        load_entry(32'h100, 1, 32'h1A10_0005, 32'h0000_0005);
        load_entry(32'h100, 2, 32'h0000_0003, 32'h0);
        run("basic", 32'h100, 8, -1, -1, 0);

        stall_pct = 70; rv_extra = 2; ws_min = 0; ws_max = 3;
        run("stalls", 32'h100, 8, -1, -1, 0);

        mem.delete();
        for (int k = 0; k < 3; k++) load_entry(32'h200, k, 32'h1A10_0100 + 32'(k * 4), 32'hC0DE_0000 + 32'(k));
        stall_pct = 0; rv_extra = 0; ws_max = 0;
        run("limit2", 32'h200, 2, -1, -1, 0);

        ws_max = 2;
        run("slverr", 32'h200, 8, 1, -1, 0);

        run("empty", 32'h200, 0, -1, -1, 1);

        ws_min = 4; ws_max = 4;
        run("abort", 32'h200, 8, -1, 0, 0);
        ws_min = 0;

        // Random lists, one starting just below the top of the address space.
        for (int r = 0; r < 6; r++) begin
            mem.delete();
            b = (r == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFF8);
            n = $urandom_range(8, 1);
            for (int k = 0; k <= n; k++) begin
                sel = $urandom_range(99);
                w0 = $urandom & 32'hFFFF_FFFC;
                w1 = $urandom;
                if (sel >= 95)      w0 = w0 | 32'h2;
                else if (sel >= 90) w0 = w0 | 32'h3;
                else if (sel >= 60) begin
                    w0 = w0 | 32'h1;
                    w1 = (w1 & 32'hFFFF_0000) | 32'($urandom_range(6, 0));
                end
                load_entry(b, k, w0, w1);
            end
            stall_pct = $urandom_range(70, 0); rv_extra = 2; ws_max = 3;
            run($sformatf("rand%0d", r), b, n, (r == 3) ? 0 : -1, -1, 0);
        end

        // Reset while the data word read is pending.
        mem.delete();
        load_entry(32'h300, 0, 32'h1A10_0010, 32'h1234_5678);
        stall_pct = 0; rv_extra = 0; cur_base = 32'h300;
        @(negedge clk);
        base_addr = 32'h300; num_entries = 16'd1; start_i = 1;
        @(negedge clk);
        start_i = 0; found = 0;
        for (int c = 0; c < 50 && !found; c++) begin
            if (bus.tcdm_req_o && bus.tcdm_add_o == 32'h304) found = 1;
            else @(negedge clk);
        end
        check("rst_mid.reached_rd_d", found, 1'b1);
        #1 rst_n = 0;
        #1 check_reset_outputs("rst_mid");
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        nrd = rd_q.size();
        repeat (6) @(negedge clk);
        check("rst_mid.no_resume_busy", busy_o, 1'b0);
        check("rst_mid.no_resume_reads", rd_q.size(), nrd);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
